// File: rtl/uart_rx_frontend.sv
// 8N1 UART receive front end: 2-flop synchronizer, mid-bit sampling baud counter,
// one-entry valid/ready holding register and sticky framing/overrun flags.
module uart_rx_frontend #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       clear_err,
  output logic       busy,
  output logic [1:0] dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e        state_q;
  logic          sync1_q;
  logic          rx_s_q;
  logic          rx_p_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    sr_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          frame_err_q;
  logic          overrun_q;
  logic          busy_q;

  // Handshake: a transfer happens on any cycle with valid && ready; data is held
  // stable while valid is high without a transfer; ready is ignored while valid is low.
  // Later non-blocking assignments in this block take priority, which gives
  // "new byte wins over drain" and "flag set wins over clear_err".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_p_q      <= 1'b1;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      sr_q        <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync1_q <= rx;
      rx_s_q  <= sync1_q;
      rx_p_q  <= rx_s_q;
      cnt_q   <= cnt_q + CNT_ONE;

      if (valid_q && ready) begin
        valid_q <= 1'b0;
      end
      if (clear_err) begin
        frame_err_q <= 1'b0;
        overrun_q   <= 1'b0;
      end

      if (!ena) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q <= '0;
            // A fresh falling edge is required, so a stuck-low line never retriggers.
            if (rx_p_q && !rx_s_q) begin
              state_q <= START;
              busy_q  <= 1'b1;
            end
          end
          START: begin
            if (cnt_q == HALF_M1) begin
              cnt_q <= '0;
              if (!rx_s_q) begin
                state_q   <= DATA;
                bit_idx_q <= 3'd0;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
          DATA: begin
            if (cnt_q == FULL_M1) begin
              cnt_q     <= '0;
              sr_q      <= {rx_s_q, sr_q[7:1]};
              bit_idx_q <= bit_idx_q + 3'd1;
              if (bit_idx_q == 3'd7) begin
                state_q <= STOP;
              end
            end
          end
          STOP: begin
            if (cnt_q == FULL_M1) begin
              cnt_q   <= '0;
              state_q <= IDLE;
              busy_q  <= 1'b0;
              if (rx_s_q) begin
                if (!valid_q || ready) begin
                  data_q  <= sr_q;
                  valid_q <= 1'b1;
                end else begin
                  overrun_q <= 1'b1;
                end
              end else begin
                frame_err_q <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend: one instance at 16 clocks/bit, one at 4 clocks/bit.
module tb_uart_rx_frontend;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       clear_err;

  logic       rx16, ready16, valid16, frame_err16, overrun16, busy16;
  logic [7:0] data16;
  logic [1:0] state16;
  logic       rx4, ready4, valid4, frame_err4, overrun4, busy4;
  logic [7:0] data4;
  logic [1:0] state4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_frontend #(.CLKS_PER_BIT(16)) dut16 (
    .clk(clk), .rst(rst), .ena(ena), .rx(rx16), .data(data16), .valid(valid16),
    .ready(ready16), .frame_err(frame_err16), .overrun(overrun16),
    .clear_err(clear_err), .busy(busy16), .dbg_state(state16)
  );

  uart_rx_frontend #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .ena(ena), .rx(rx4), .data(data4), .valid(valid4),
    .ready(ready4), .frame_err(frame_err4), .overrun(overrun4),
    .clear_err(clear_err), .busy(busy4), .dbg_state(state4)
  );

  // Advance n active edges and settle just after the last one.
  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel4, input logic v);
    if (sel4) rx4 = v;
    else      rx16 = v;
  endtask

  // Called just after an active edge; the next edge is edge 0 of the frame.
  task automatic tx_frame(input bit sel4, input logic [7:0] b, input logic stop_bit);
    int n;
    n = sel4 ? 4 : 16;
    drive(sel4, 1'b0);
    hold(n);
    for (int i = 0; i < 8; i++) begin
      drive(sel4, b[i]);
      hold(n);
    end
    drive(sel4, stop_bit);
    hold(n);
    drive(sel4, 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    hold(3);
    checks++;
    if ({data16, valid16, frame_err16, overrun16, busy16, state16} !== 14'h0) begin
      errors++;
      $display("FAIL reset16: got data=%h v=%b fe=%b ov=%b busy=%b st=%0d, expected all 0",
               data16, valid16, frame_err16, overrun16, busy16, state16);
    end
    checks++;
    if ({data4, valid4, frame_err4, overrun4, busy4, state4} !== 14'h0) begin
      errors++;
      $display("FAIL reset4: got data=%h v=%b fe=%b ov=%b busy=%b st=%0d, expected all 0",
               data4, valid4, frame_err4, overrun4, busy4, state4);
    end
    rst = 1'b0;
    hold(4);
    checks++;
    if ({valid16, busy16, valid4, busy4} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected 0000", {valid16, busy16, valid4, busy4});
    end
  endtask

  task automatic test_basic_frame;
    ready16 = 1'b1;
    fork
      tx_frame(1'b0, 8'hA5, 1'b1);
      begin
        hold(2);
        checks++;
        if (busy16 !== 1'b0) begin
          errors++;
          $display("FAIL busy_edge1: got %b expected 0", busy16);
        end
        hold(1);
        checks++;
        if (busy16 !== 1'b1) begin
          errors++;
          $display("FAIL busy_edge2: got %b expected 1", busy16);
        end
        hold(151);
        checks++;
        if ({valid16, busy16} !== 2'b01) begin
          errors++;
          $display("FAIL pre_stop153: got v/busy=%b expected 01", {valid16, busy16});
        end
        hold(1);
        checks++;
        if ({valid16, busy16, frame_err16, overrun16, data16} !== {4'b1000, 8'hA5}) begin
          errors++;
          $display("FAIL stop154: got v=%b busy=%b fe=%b ov=%b data=%h expected 1 0 0 0 a5",
                   valid16, busy16, frame_err16, overrun16, data16);
        end
        hold(1);
        checks++;
        if (valid16 !== 1'b0) begin
          errors++;
          $display("FAIL valid_pulse155: got %b expected 0", valid16);
        end
      end
    join
    hold(4);
  endtask

  task automatic test_overrun;
    ready16 = 1'b0;
    fork
      tx_frame(1'b0, 8'h3C, 1'b1);
      begin
        hold(155);
        checks++;
        if ({valid16, data16} !== {1'b1, 8'h3C}) begin
          errors++;
          $display("FAIL first_byte: got v=%b data=%h expected 1 3c", valid16, data16);
        end
      end
    join
    hold(5);
    fork
      tx_frame(1'b0, 8'hC3, 1'b1);
      begin
        hold(154);
        checks++;
        if (overrun16 !== 1'b0) begin
          errors++;
          $display("FAIL overrun_early: got %b expected 0", overrun16);
        end
        hold(1);
        checks++;
        if ({valid16, overrun16, frame_err16, data16} !== {3'b110, 8'h3C}) begin
          errors++;
          $display("FAIL overrun_set: got v=%b ov=%b fe=%b data=%h expected 1 1 0 3c",
                   valid16, overrun16, frame_err16, data16);
        end
      end
    join
    checks++;
    if ({valid16, overrun16, data16} !== {2'b11, 8'h3C}) begin
      errors++;
      $display("FAIL overrun_sticky: got v=%b ov=%b data=%h expected 1 1 3c", valid16, overrun16, data16);
    end
    ready16 = 1'b1;
    hold(1);
    checks++;
    if (valid16 !== 1'b0) begin
      errors++;
      $display("FAIL drain: got valid=%b expected 0", valid16);
    end
    clear_err = 1'b1;
    hold(1);
    clear_err = 1'b0;
    checks++;
    if (overrun16 !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: got %b expected 0", overrun16);
    end
    hold(3);
  endtask

  task automatic test_frame_err;
    ready16 = 1'b1;
    fork
      tx_frame(1'b0, 8'h55, 1'b0);
      begin
        hold(154);
        checks++;
        if (frame_err16 !== 1'b0) begin
          errors++;
          $display("FAIL fe_early: got %b expected 0", frame_err16);
        end
        hold(1);
        checks++;
        if ({valid16, frame_err16, overrun16, busy16} !== 4'b0100) begin
          errors++;
          $display("FAIL fe_set: got v/fe/ov/busy=%b expected 0100",
                   {valid16, frame_err16, overrun16, busy16});
        end
        hold(1);
        checks++;
        if (valid16 !== 1'b0) begin
          errors++;
          $display("FAIL fe_no_valid: got %b expected 0", valid16);
        end
      end
    join
    hold(2);
    clear_err = 1'b1;
    hold(1);
    clear_err = 1'b0;
    checks++;
    if (frame_err16 !== 1'b0) begin
      errors++;
      $display("FAIL fe_clear: got %b expected 0", frame_err16);
    end
    hold(2);
    fork
      tx_frame(1'b0, 8'h55, 1'b0);
      begin
        hold(154);
        clear_err = 1'b1;
        hold(1);
        clear_err = 1'b0;
        checks++;
        if (frame_err16 !== 1'b1) begin
          errors++;
          $display("FAIL fe_set_beats_clear: got %b expected 1", frame_err16);
        end
      end
    join
    clear_err = 1'b1;
    hold(1);
    clear_err = 1'b0;
    checks++;
    if (frame_err16 !== 1'b0) begin
      errors++;
      $display("FAIL fe_clear2: got %b expected 0", frame_err16);
    end
    hold(3);
  endtask

  task automatic test_glitch;
    fork
      begin
        rx16 = 1'b0;
        hold(3);
        rx16 = 1'b1;
      end
      begin
        hold(2);
        checks++;
        if (busy16 !== 1'b0) begin
          errors++;
          $display("FAIL glitch_busy1: got %b expected 0", busy16);
        end
        hold(1);
        checks++;
        if (busy16 !== 1'b1) begin
          errors++;
          $display("FAIL glitch_busy2: got %b expected 1", busy16);
        end
        hold(7);
        checks++;
        if (busy16 !== 1'b1) begin
          errors++;
          $display("FAIL glitch_busy9: got %b expected 1", busy16);
        end
        hold(1);
        checks++;
        if ({valid16, frame_err16, overrun16, busy16} !== 4'b0000) begin
          errors++;
          $display("FAIL glitch_abort10: got v/fe/ov/busy=%b expected 0000",
                   {valid16, frame_err16, overrun16, busy16});
        end
      end
    join
    hold(200);
    checks++;
    if ({valid16, busy16, frame_err16, overrun16} !== 4'b0000) begin
      errors++;
      $display("FAIL glitch_quiet: got %b expected 0000", {valid16, busy16, frame_err16, overrun16});
    end
  endtask

  task automatic test_reset_midframe;
    ready16 = 1'b1;
    fork
      tx_frame(1'b0, 8'h81, 1'b1);
      begin
        hold(86);
        checks++;
        if ({busy16, state16} !== 3'b110) begin
          errors++;
          $display("FAIL mid_data: got busy=%b st=%0d expected 1 2", busy16, state16);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({data16, valid16, frame_err16, overrun16, busy16, state16} !== 14'h0) begin
          errors++;
          $display("FAIL mid_reset: got data=%h v=%b fe=%b ov=%b busy=%b st=%0d expected all 0",
                   data16, valid16, frame_err16, overrun16, busy16, state16);
        end
      end
    join
    hold(2);
    rst = 1'b0;
    hold(4);
    checks++;
    if ({valid16, busy16} !== 2'b00) begin
      errors++;
      $display("FAIL post_reset_quiet: got %b expected 00", {valid16, busy16});
    end
    fork
      tx_frame(1'b0, 8'h81, 1'b1);
      begin
        hold(155);
        checks++;
        if ({valid16, frame_err16, overrun16, data16} !== {3'b100, 8'h81}) begin
          errors++;
          $display("FAIL after_reset_frame: got v=%b fe=%b ov=%b data=%h expected 1 0 0 81",
                   valid16, frame_err16, overrun16, data16);
        end
      end
    join
    hold(4);
  endtask

  task automatic test_back_to_back;
    int         v_cnt;
    int         v_edge[2];
    logic [7:0] v_data[2];
    v_cnt = 0;
    v_edge[0] = -1;
    v_edge[1] = -1;
    v_data[0] = 8'hxx;
    v_data[1] = 8'hxx;
    ready4 = 1'b1;
    fork
      begin
        tx_frame(1'b1, 8'h00, 1'b1);
        tx_frame(1'b1, 8'hFF, 1'b1);
      end
      begin
        for (int e = 0; e < 90; e++) begin
          hold(1);
          if (e == 41) begin
            checks++;
            if (busy4 !== 1'b0) begin
              errors++;
              $display("FAIL b2b_idle41: got busy=%b expected 0", busy4);
            end
          end
          if (e == 42) begin
            checks++;
            if (busy4 !== 1'b1) begin
              errors++;
              $display("FAIL b2b_start42: got busy=%b expected 1", busy4);
            end
          end
          if (valid4 === 1'b1) begin
            if (v_cnt < 2) begin
              v_edge[v_cnt] = e;
              v_data[v_cnt] = data4;
            end
            v_cnt++;
          end
        end
      end
    join
    checks++;
    if (v_cnt !== 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d valid cycles expected 2", v_cnt);
    end
    checks++;
    if ({v_data[0], v_data[1]} !== 16'h00FF) begin
      errors++;
      $display("FAIL b2b_data: got %h %h expected 00 ff", v_data[0], v_data[1]);
    end
    checks++;
    if (v_edge[0] !== 40 || v_edge[1] - v_edge[0] !== 40) begin
      errors++;
      $display("FAIL b2b_timing: got edges %0d %0d expected 40 80", v_edge[0], v_edge[1]);
    end
    checks++;
    if ({frame_err4, overrun4} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_flags: got fe/ov=%b expected 00", {frame_err4, overrun4});
    end
  endtask

  initial begin
    rst       = 1'b1;
    ena       = 1'b1;
    clear_err = 1'b0;
    rx16      = 1'b1;
    rx4       = 1'b1;
    ready16   = 1'b0;
    ready4    = 1'b0;
    #1;
    test_reset;
    test_basic_frame;
    test_overrun;
    test_frame_err;
    test_glitch;
    test_reset_midframe;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_frontend.md
# uart_rx_frontend

Serial receive front end inside `tt_um_top`, directly downstream of the dedicated input pins. It takes the asynchronous serial line on `ui_in[0]` and recovers 8N1 UART frames with a mid-bit sampling baud counter. Recovered bytes go to the core logic over a one-entry valid/ready holding register, and the core in turn drives `uo_out`. Framing and overrun errors are reported as sticky flags.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Must be even and ≥ 4.
- `clk`  in  1  system clock, the same `clk` as the top level.
- `rst`  in  1  asynchronous, active-high reset. The top level drives it from `~rst_n`.
- `ena`  in  1  design enable. When low, the FSM is forced to IDLE at the next edge, any in-progress frame is discarded, and the holding register and flags are kept.
- `rx`  in  1  raw serial line (`ui_in[0]`), asynchronous, idle high.
- `data`  out  8  received byte. Valid only while `valid` is high.
- `valid`  out  1  holding register full.
- `ready`  in  1  consumer accepts `data` this cycle.
- `frame_err`  out  1  sticky: a stop bit was sampled low.
- `overrun`  out  1  sticky: a byte completed while the holding register was full.
- `clear_err`  in  1  synchronous clear of both sticky flags.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **Synchronizer:** `rx` passes through a 2-flop synchronizer (both flops reset to 1), giving `rx_s`. A previous-value flop `rx_p` also resets to 1. The FSM uses `rx_s` only.
- **Counter:** a baud counter of width `clog2(CLKS_PER_BIT)`. It is cleared to 0 on every state entry and after every sampled bit, and increments every cycle otherwise. Let H = `CLKS_PER_BIT/2` and N = `CLKS_PER_BIT`.
- **IDLE:**
  - If `ena` is high and `rx_p`=1, `rx_s`=0 (falling edge), go to START.
  - A line held low never retriggers, because a new edge is required.
- **START:** when cnt == H−1, sample `rx_s`.
  - If 0, go to DATA with bit index 0.
  - If 1, treat it as a glitch and return to IDLE without flagging.
- **DATA:** when cnt == N−1, shift `rx_s` into a shift register LSB-first and increment the bit index.
  - After bit 7, go to STOP.
- **STOP:** when cnt == N−1, sample `rx_s` and return to IDLE.
  - If `rx_s` = 1 and the holding register is free (`valid`=0, or `valid`&&`ready` this cycle), load `data` and set `valid`.
  - If `rx_s` = 1 and the register is not free, set `overrun`. The new byte is dropped and the old `data`/`valid` are unchanged.
  - If `rx_s` = 0, set `frame_err` and discard the byte.
- **Handshake:**
  - A transfer occurs on any cycle with `valid`&&`ready`.
  - `valid` falls on the next edge unless a new byte loads on that same edge, in which case `valid` stays high and `data` updates.
  - `data` is stable while `valid` is high and no transfer occurs.
  - `ready` is ignored while `valid` is low.
- **Error flags:**
  - `clear_err` clears both flags.
  - If a flag is set and cleared on the same edge, the set wins.
- **Reset values:** `data`=0x00, `valid`=0, `frame_err`=0, `overrun`=0, `busy`=0, FSM=IDLE, counter and shift register = 0.
  - Reset asserted mid-frame aborts the frame and produces no `valid`.

## Timing
- Edge 0 is the clock edge at which the first synchronizer flop first samples `rx` low.
- FSM entry:
  - `rx_s`=0 is visible after edge 1.
  - START is entered at edge 2.
- Sample points:
  - Start bit: edge 2+H.
  - Data bit k: edge 2+H+(k+1)·N.
  - Stop bit: edge 2+H+9N. With N=16 this is edge 154.
- `valid`, `frame_err` and `overrun` all update at the stop-sample edge. `busy` falls at the same edge.
- `busy` rises at edge 2.
- Back-to-back frames: the next start edge may arrive as early as the cycle after the stop sample, and the receiver handles it (IDLE to START with no dead cycles beyond edge detection).
- Throughput: one byte per 10·N cycles at full line rate. The consumer must drain within one frame time to avoid overrun.

## Test plan
- Reset, then a 0xA5 frame at N=16 with `ready`=1 → `valid` pulses for exactly 1 cycle after edge 154, `data`=0xA5, both flags 0.
- Two frames 0x3C then 0xC3 with `ready`=0 throughout → first `valid` shows `data`=0x3C. At the second stop sample `overrun`=1 and `data` remains 0x3C. Then `ready`=1 drops `valid`.
- Frame 0x55 with the stop bit driven low → no `valid`, `frame_err`=1 at edge 154. `clear_err` then clears it. `clear_err` asserted on the same edge as a new framing error → `frame_err` stays 1.
- A 3-cycle low glitch on `rx` (shorter than H) → START aborts to IDLE, `busy` high for H cycles, no `valid`, no flags.
- `rst` asserted at data bit 4 of a frame → all outputs at reset values immediately. A following clean 0x81 frame is received correctly.
- Back-to-back 0x00, 0xFF with `ready`=1 and N=4 → both bytes delivered in order, with `valid` edges exactly 40 cycles apart.
